// File: rtl/dl_boot_sequencer.sv
// rtl/dl_boot_sequencer.sv - core bring-up sequencer around the HPS ROM/DIP download stream
// Decodes ROM bytes into regions, captures DIP bytes, and gates core_reset on load completion.
module dl_boot_sequencer #(
    parameter logic [7:0]  ROM_INDEX     = 8'd0,
    parameter logic [7:0]  DIP_INDEX     = 8'd254,
    parameter logic [16:0] SND_BASE      = 17'h08000,
    parameter logic [16:0] GFX_BASE      = 17'h0C000,
    parameter logic [16:0] ROM_BYTES     = 17'h1C000,
    parameter int          SETTLE_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        core_reset,
    output logic        rom_wr,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [1:0]  rom_region,
    output logic [63:0] dip_sw,
    output logic        dips_valid,
    output logic        load_error,
    output logic        rom_download
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [17:0] SETTLE_LOAD = 18'(SETTLE_CYCLES);
    localparam logic [17:0] CNT_MAX     = '1;

    state_t      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic        dl_prev_q, dl_prev_d;
    logic        core_reset_q, core_reset_d;
    logic        load_error_q, load_error_d;
    logic        rom_wr_q, rom_wr_d;
    logic [16:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [1:0]  rom_region_q, rom_region_d;
    logic [63:0] dip_sw_q, dip_sw_d;
    logic        dips_valid_q, dips_valid_d;

    logic        rom_dl;
    logic        rom_accept;
    logic        dip_accept;
    logic        load_end;
    logic [17:0] cnt_inc;

    always_comb begin
        rom_dl     = ioctl_download && (ioctl_index == ROM_INDEX) && !reset;
        rom_accept = ioctl_wr && rom_dl && (ioctl_addr[24:17] == 8'd0)
                     && (ioctl_addr[16:0] < ROM_BYTES);
        dip_accept = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == 22'd0);
        load_end   = dl_prev_q && !rom_dl;
        cnt_inc    = (rom_accept && (cnt_q != CNT_MAX)) ? cnt_q + 18'd1 : cnt_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_error_d = load_error_q;

        case (state_q)
            BOOT: begin
                if (rom_dl) state_d = LOAD;
            end
            LOAD: begin
                // The decision uses the count including a write accepted this same cycle.
                cnt_d = cnt_inc;
                if (load_end) begin
                    if (cnt_inc >= {1'b0, ROM_BYTES}) begin
                        state_d      = SETTLE;
                        cnt_d        = SETTLE_LOAD;
                        load_error_d = 1'b0;
                    end else begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (rom_dl) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    cnt_d = SETTLE_LOAD;
                end else if (cnt_q == 18'd1) begin
                    state_d = RUN;
                    cnt_d   = 18'd0;
                end else begin
                    cnt_d = cnt_q - 18'd1;
                end
            end
            RUN: begin
                if (rom_dl) begin
                    state_d = LOAD;
                end else if (user_reset) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ERROR: begin
                if (rom_dl) state_d = LOAD;
            end
            default: begin
                state_d = BOOT;
                cnt_d   = 18'd0;
            end
        endcase

        // Fresh load: restart the byte count, counting a byte that arrives on the entry cycle.
        if ((state_d == LOAD) && (state_q != LOAD)) begin
            cnt_d        = {17'd0, rom_accept};
            load_error_d = 1'b0;
        end

        core_reset_d = (state_d != RUN);
        dl_prev_d    = rom_dl;
    end

    always_comb begin
        rom_wr_d     = rom_accept;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        rom_region_d = rom_region_q;
        if (rom_accept) begin
            rom_addr_d = ioctl_addr[16:0];
            rom_data_d = ioctl_dout;
            if (ioctl_addr[16:0] < SND_BASE) begin
                rom_region_d = 2'd0;
            end else if (ioctl_addr[16:0] < GFX_BASE) begin
                rom_region_d = 2'd1;
            end else begin
                rom_region_d = 2'd2;
            end
        end

        dip_sw_d     = dip_sw_q;
        dips_valid_d = dips_valid_q || dip_accept;
        if (dip_accept) begin
            dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= BOOT;
            cnt_q        <= 18'd0;
            dl_prev_q    <= 1'b0;
            core_reset_q <= 1'b1;
            load_error_q <= 1'b0;
            rom_wr_q     <= 1'b0;
            rom_addr_q   <= 17'd0;
            rom_data_q   <= 8'd0;
            rom_region_q <= 2'd0;
            dip_sw_q     <= 64'd0;
            dips_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dl_prev_q    <= dl_prev_d;
            core_reset_q <= core_reset_d;
            load_error_q <= load_error_d;
            rom_wr_q     <= rom_wr_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            rom_region_q <= rom_region_d;
            dip_sw_q     <= dip_sw_d;
            dips_valid_q <= dips_valid_d;
        end
    end

    assign core_reset   = core_reset_q;
    assign rom_wr       = rom_wr_q;
    assign rom_addr     = rom_addr_q;
    assign rom_data     = rom_data_q;
    assign rom_region   = rom_region_q;
    assign dip_sw       = dip_sw_q;
    assign dips_valid   = dips_valid_q;
    assign load_error   = load_error_q;
    assign rom_download = rom_dl;

endmodule

// File: tb/tb_dl_boot_sequencer.sv
// tb/tb_dl_boot_sequencer.sv - scoreboard bench for dl_boot_sequencer
// Image size and region bases are scaled down so full loads stay short.
module tb_dl_boot_sequencer;

    localparam logic [16:0] TB_ROM_BYTES = 17'h00400;
    localparam logic [16:0] TB_SND       = 17'h00100;
    localparam logic [16:0] TB_GFX       = 17'h00200;
    localparam int          SETTLE       = 1024;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic        core_reset;
    logic        rom_wr;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  rom_region;
    logic [63:0] dip_sw;
    logic        dips_valid;
    logic        load_error;
    logic        rom_download;

    dl_boot_sequencer #(
        .ROM_BYTES    (TB_ROM_BYTES),
        .SND_BASE     (TB_SND),
        .GFX_BASE     (TB_GFX),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .user_reset    (user_reset),
        .core_reset    (core_reset),
        .rom_wr        (rom_wr),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_region    (rom_region),
        .dip_sw        (dip_sw),
        .dips_valid    (dips_valid),
        .load_error    (load_error),
        .rom_download  (rom_download)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic [1:0]  region;
        int          stamp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   watch_low = 1'b0;
    bit   watch_high = 1'b0;
    int   low_cnt = 0;
    int   high_cnt = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] region_of(input logic [16:0] a);
        if (a < TB_SND) return 2'd0;
        if (a < TB_GFX) return 2'd1;
        return 2'd2;
    endfunction

    // Monitor: every rom_wr must match the oldest outstanding accepted byte, one cycle late.
    always @(negedge clk_sys) begin
        if (watch_low && !core_reset) low_cnt++;
        if (watch_high && core_reset) high_cnt++;
        if (rom_wr === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rom_wr_unexpected: got strobe at addr 0x%0h, expected no strobe", rom_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rom_wr_latency", 64'(cyc), 64'(e.stamp));
                chk("rom_addr", 64'(rom_addr), 64'(e.addr));
                chk("rom_data", 64'(rom_data), 64'(e.data));
                chk("rom_region", 64'(rom_region), 64'(e.region));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        exp_t e;
        if (ioctl_download && idx == 8'd0 && a < 25'(TB_ROM_BYTES)) begin
            e.addr   = a[16:0];
            e.data   = d;
            e.region = region_of(a[16:0]);
            e.stamp  = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        push_exp(idx, a, d);
        tick();
        ioctl_wr = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic rom_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [24:0] a;
            a = 25'(first + i);
            wr_byte(8'd0, a, a[7:0]);
        end
    endtask

    task automatic start_dl();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
    endtask

    // Ticks until core_reset is seen low; returns ticks taken, or bound if it never fell.
    task automatic measure_release(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (core_reset && n < bound);
    endtask

    initial begin
        int n;
        int hold;
        reset          = 1'b1;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        user_reset     = 1'b0;
        tick();
        tick();
        chk("reset_rom_download", 64'(rom_download), 64'd0);
        ioctl_download = 1'b0;
        tick();
        chk("reset_core_reset", 64'(core_reset), 64'd1);
        chk("reset_rom_wr", 64'(rom_wr), 64'd0);
        chk("reset_load_error", 64'(load_error), 64'd0);
        chk("reset_dips_valid", 64'(dips_valid), 64'd0);
        chk("reset_dip_sw", dip_sw, 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("boot_core_reset", 64'(core_reset), 64'd1);

        // Short image: ERROR, reset held, user_reset ignored.
        start_dl();
        chk("rom_download_active", 64'(rom_download), 64'd1);
        rom_bytes(0, 'h100);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("short_load_error", 64'(load_error), 64'd1);
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        hold = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (core_reset) hold++;
        end
        chk("error_hold", 64'(hold), 64'd5000);

        // One byte short plus two out-of-range writes must still be short.
        start_dl();
        chk("error_clear_on_load", 64'(load_error), 64'd0);
        rom_bytes(0, int'(TB_ROM_BYTES) - 1);
        wr_byte(8'd0, 25'(TB_ROM_BYTES), 8'hAA);
        wr_byte(8'd0, 25'h0020000, 8'hBB);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("oob_not_counted", 64'(load_error), 64'd1);
        measure_release(1200, n);
        chk("oob_reset_held", 64'(n), 64'd1200);

        // Full image: release exactly SETTLE cycles after SETTLE entry.
        start_dl();
        rom_bytes(0, int'(TB_ROM_BYTES));
        ioctl_download = 1'b0;
        measure_release(3000, n);
        chk("full_load_release", 64'(n), 64'(SETTLE + 1));
        chk("full_load_error", 64'(load_error), 64'd0);

        // DIP capture while running.
        chk("dips_valid_before", 64'(dips_valid), 64'd0);
        watch_high     = 1'b1;
        ioctl_download = 1'b1;
        wr_byte(8'd254, 25'd0, 8'h7F);
        wr_byte(8'd254, 25'd1, 8'hC2);
        wr_byte(8'd254, 25'd8, 8'h55);
        ioctl_download = 1'b0;
        tick();
        watch_high = 1'b0;
        chk("dip_core_reset", 64'(high_cnt), 64'd0);
        chk("dip_low_bytes", 64'(dip_sw[15:0]), 64'h0000_0000_0000_C27F);
        chk("dip_addr8_ignored", 64'(dip_sw[63:16]), 64'd0);
        chk("dips_valid_set", 64'(dips_valid), 64'd1);

        // Single user_reset pulse.
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        chk("ureset_asserts", 64'(core_reset), 64'd1);
        measure_release(2000, n);
        chk("ureset_release", 64'(n + 1), 64'(SETTLE + 1));

        // Re-pulse 500 cycles in reloads the settle count.
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        hold = 0;
        for (int i = 0; i < 499; i++) begin
            tick();
            if (!core_reset) hold++;
        end
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        chk("ureset_repulse_high", 64'(hold), 64'd0);
        measure_release(3000, n);
        chk("ureset_repulse_release", 64'(501 + n), 64'(500 + SETTLE + 1));

        // Download and user_reset together: LOAD wins and the first byte counts.
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        user_reset     = 1'b1;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'h00;
        ioctl_wr       = 1'b1;
        push_exp(8'd0, 25'd0, 8'h00);
        tick();
        ioctl_wr   = 1'b0;
        user_reset = 1'b0;
        chk("priority_core_reset", 64'(core_reset), 64'd1);
        low_cnt   = 0;
        watch_low = 1'b1;
        tick();
        tick();
        tick();
        rom_bytes(1, int'(TB_ROM_BYTES) - 1);
        watch_low = 1'b0;
        chk("priority_hold_in_load", 64'(low_cnt), 64'd0);
        ioctl_download = 1'b0;
        measure_release(3000, n);
        chk("priority_release", 64'(n), 64'(SETTLE + 1));

        // Reset mid-download restarts the byte count.
        start_dl();
        rom_bytes(0, 'h300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rom_bytes('h100, 'h300);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("reset_restart_count", 64'(load_error), 64'd1);
        measure_release(1500, n);
        chk("reset_restart_hold", 64'(n), 64'd1500);

        // Recovery load after the error.
        start_dl();
        chk("recover_error_clear", 64'(load_error), 64'd0);
        rom_bytes(0, int'(TB_ROM_BYTES));
        ioctl_download = 1'b0;
        measure_release(3000, n);
        chk("recover_release", 64'(n), 64'(SETTLE + 1));
        chk("recover_load_error", 64'(load_error), 64'd0);

        tick();
        tick();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
